fft_sdf_ctrl: RTL
=================

Name: fft_sdf_ctrl

Overview:
- Sequencer for a radix-2 single-path delay-feedback FFT pipeline of LAYERS stages.
- Each stage is one RAM-based delay line of 2^(l-1) samples plus a butterfly with BF_LAT cycles of latency.
- Accepts contiguous N-point frames, back-to-back if desired, and drives per-stage delay write-enables, butterfly select and twiddle ROM addresses.
- After the last frame it flushes the pipeline with zero samples and flags output frame boundaries.

Parameters:
LAYERS, 10, number of stages; N = 2^LAYERS points; legal range 2..14
BF_LAT, 1, butterfly pipeline latency per stage, in cycles

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
in_valid  in  1  input sample present; must stay high for all N samples of a frame
in_ready  out  1  controller accepts a frame start or continuation
flush  out  1  datapath muxes zero samples into stage LAYERS
stage_wea  out  LAYERS  bit l-1 enables delay-line write/shift of layer l
bf_sel  out  LAYERS  bit l-1: 0 = fill delay (bypass), 1 = butterfly, for layer l
tw_addr  out  LAYERS*(LAYERS-1)  slice l-1 is the twiddle ROM address for layer l
out_valid  out  1  pipeline output sample valid
out_first  out  1  output sample index 0 of a frame
out_last  out  1  output sample index N-1 of a frame
done  out  1  one-cycle pulse when the flush completes
err_gap  out  1  one-cycle pulse on in_valid drop mid-frame

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, all counters 0. All outputs 0 except in_ready=1.
- Output timing: every output is registered and refers to the sample accepted in the previous cycle. CTRL_LAT = 1.
- Stage order: layer LAYERS (delay 2^(LAYERS-1)) first, layer 1 last.
- OFFSET_l = (N - 2^l) + (LAYERS - l)*BF_LAT.
- TOTAL_LAT = N - 1 + LAYERS*BF_LAT.
- Counters:
  - cyc: mod-N, starts at 0 on the first accepted sample, increments every non-IDLE cycle.
  - gcnt: saturates at TOTAL_LAT, cleared in IDLE.
  - pend: 3-bit count of frames in flight; +1 at input index N-1, -1 at out_last. Simultaneous ±1 leaves it unchanged.
- Per-stage local index: lcnt_l = (cyc - OFFSET_l) mod N, computed with N-bit wraparound.
- Per-stage outputs:
  - stage_wea[l-1] = (state != IDLE) && gcnt >= OFFSET_l. All enables drop together when the flush ends.
  - bf_sel[l-1] = bit (l-1) of lcnt_l.
  - tw_addr slice l-1 = lcnt_l[l-2:0] << (LAYERS-l), width LAYERS-1. Layer 1 is always 0.
- Output side:
  - out_valid = gcnt >= TOTAL_LAT && pend != 0.
  - Output index = lcnt at output = (cyc - TOTAL_LAT) mod N.
  - out_first at index 0, out_last at index N-1, both gated by out_valid.
- State machine:
  - IDLE: in_ready=1. in_valid=1 → RUN; that sample is index 0.
  - RUN: in_ready=1.
    - in_valid=0 with cyc != N-1 (mid-frame gap) → err_gap pulse, abort to IDLE. All in-flight frames are discarded, no out_valid for them.
    - At cyc = N-1: in_valid next cycle continues as the next frame (back-to-back, no bubble); otherwise → FLUSH.
  - FLUSH: in_ready=0, flush=1, in_valid ignored. Stays until out_last with pend becoming 0 → DONE.
  - DONE: done=1 for one cycle, flush=0, all stage_wea=0 → IDLE.
- Unused state encodings go to IDLE.
- pend never exceeds ceil(TOTAL_LAT/N)+1. Overflow is impossible for legal parameters; the bench asserts it.
- Reset asserted mid-frame or mid-flush returns to IDLE immediately. No done or err_gap pulse is produced.

Test Plan:
1. LAYERS=3, BF_LAT=1 (N=8, offsets 0/5/8, TOTAL_LAT=10); single frame with in_valid high cycles t0..t0+7:
   - stage_wea[2] rises at t0+1, stage_wea[1] at t0+6, stage_wea[0] at t0+9.
   - out_valid t0+11..t0+18, out_first at t0+11, out_last at t0+18.
   - done at t0+19; in_ready=0 from t0+9 to t0+19, 1 again at t0+20.
2. Same config, bf_sel[2] check: 0 for the first 4 enabled cycles, 1 for the next 4, repeating. bf_sel[1] toggles every 2 cycles starting at t0+6.
3. Same config, tw_addr check: layer 3 slice steps 0,1,2,3 during bf_sel[2]=1. Layer 2 slice alternates 0,2. Layer 1 slice is always 0.
4. Three back-to-back frames (24 consecutive in_valid cycles):
   - out_valid is continuous for 24 cycles.
   - 3 out_first and 3 out_last pulses, pend peaks at 2.
   - A single done pulse.
5. in_valid drops at input index 4 of the second frame → err_gap pulse, IDLE next cycle, no further out_valid, in_ready=1.
6. rst pulled low during FLUSH → all outputs 0 and in_ready=1 immediately. A new frame afterwards reproduces the timing of scenario 1.

Source files
------------

// File: rtl/fft_sdf_ctrl.sv
// Control sequencer for a radix-2 single-path delay-feedback FFT pipeline.
// Drives per-stage delay enables, butterfly selects, twiddle addresses and output framing.
module fft_sdf_ctrl #(
    parameter int LAYERS = 10,
    parameter int BF_LAT = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         flush,
    output logic [LAYERS-1:0]            stage_wea,
    output logic [LAYERS-1:0]            bf_sel,
    output logic [LAYERS*(LAYERS-1)-1:0] tw_addr,
    output logic                         out_valid,
    output logic                         out_first,
    output logic                         out_last,
    output logic                         done,
    output logic                         err_gap
);
    localparam int N         = 1 << LAYERS;
    localparam int TOTAL_LAT = N - 1 + LAYERS * BF_LAT;
    localparam int GW        = $clog2(TOTAL_LAT + 1);
    localparam int TW        = LAYERS - 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

    state_e            state_q, state_d;
    logic [LAYERS-1:0] cyc_q, cyc_d;
    logic [GW-1:0]     gcnt_q, gcnt_d;
    logic [2:0]        pend_q, pend_d;
    logic              err_q, err_d;
    logic              active, inc;
    logic [LAYERS-1:0] oidx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            gcnt_q  <= '0;
            pend_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            gcnt_q  <= gcnt_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    // All outputs decode registered state, so they describe the sample taken last cycle.
    assign active    = (state_q == RUN) || (state_q == FLUSH);
    assign in_ready  = (state_q == IDLE) || (state_q == RUN);
    assign flush     = (state_q == FLUSH);
    assign done      = (state_q == DONE);
    assign err_gap   = err_q;
    assign oidx      = cyc_q - LAYERS'(TOTAL_LAT % N);
    assign out_valid = (gcnt_q >= GW'(TOTAL_LAT)) && (pend_q != 3'd0);
    assign out_first = out_valid && (oidx == '0);
    assign out_last  = out_valid && (oidx == '1);
    assign inc       = (state_q == RUN) && (cyc_q == '1);

    for (genvar gl = 0; gl < LAYERS; gl++) begin : g_layer
        localparam int                OFF   = (N - (1 << (gl + 1))) + (LAYERS - 1 - gl) * BF_LAT;
        localparam logic [LAYERS-1:0] OFF_M = LAYERS'(OFF % N);
        // Only the low gl+1 bits of the local index feed bf_sel and the twiddle address.
        logic [gl:0] lcnt;
        assign lcnt          = cyc_q[gl:0] - OFF_M[gl:0];
        assign stage_wea[gl] = active && (gcnt_q >= GW'(OFF));
        assign bf_sel[gl]    = stage_wea[gl] && lcnt[gl];
        if (gl == 0) begin : g_l1
            assign tw_addr[TW-1:0] = '0;
        end else begin : g_ln
            assign tw_addr[gl*TW +: TW] = stage_wea[gl] ? (TW'(lcnt[gl-1:0]) << (TW - gl)) : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        gcnt_d  = gcnt_q;
        pend_d  = pend_q;
        err_d   = 1'b0;
        if (active) begin
            cyc_d  = cyc_q + LAYERS'(1);
            pend_d = pend_q + 3'(inc) - 3'(out_last);
            if (gcnt_q < GW'(TOTAL_LAT)) gcnt_d = gcnt_q + GW'(1);
        end
        case (state_q)
            IDLE: begin
                cyc_d  = '0;
                gcnt_d = '0;
                pend_d = '0;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (!in_valid && cyc_q != '1) begin
                    // Gap inside a frame: drop everything in flight.
                    err_d   = 1'b1;
                    state_d = IDLE;
                    cyc_d   = '0;
                    gcnt_d  = '0;
                    pend_d  = '0;
                end else if (!in_valid) begin
                    state_d = FLUSH;
                end
            end
            FLUSH:   if (out_last && pend_d == 3'd0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule
